// File: rtl/pkt_gen_if.sv
// pkt_gen_if: metadata stream from a traffic generator to an ingress block.
//   gen_meta : metadata word (destination, source id, sequence, timestamp)
//   gen_en   : word-valid strobe, one cycle per word, no backpressure
// master modport drives the stream (generator), slave modport receives it.
interface pkt_gen_if #(
  parameter int META_WIDTH = 32
);
  logic [META_WIDTH-1:0] gen_meta;
  logic                  gen_en;

  modport master (output gen_meta, output gen_en);
  modport slave  (input  gen_meta, input  gen_en);
endinterface

// File: rtl/pkt_gen.sv
// pkt_gen: per-ingress-port traffic generator.
// Software programs PKT_CNT, INTERVAL, MODE/FIXED_DST and SEED, then pulses
// start. The block emits PKT_CNT metadata words, one every max(INTERVAL,1)
// cycles, and holds experimenting high while the run is active.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   cfg_we/addr/wdata     : register write port (0 PKT_CNT, 1 INTERVAL,
//                           2 MODE[1:0]/FIXED_DST[3:2], 3 SEED)
//   start, stop           : run request, abort request
//   meta_if (master)      : gen_meta / gen_en metadata stream
//   experimenting, done   : run status
//   sent_cnt              : words emitted in the current or last run
module pkt_gen #(
  parameter logic [1:0] SRC_ID     = 2'd0,
  parameter int         META_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic             start,
  input  logic             stop,
  pkt_gen_if.master        meta_if,
  output logic             experimenting,
  output logic             done,
  output logic [15:0]      sent_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] SEED_DFLT = 16'hACE1;

  state_t      state;

  logic [15:0] pkt_cnt_r;
  logic [7:0]  interval_r;
  logic [1:0]  mode_r;
  logic [1:0]  fixed_dst_r;
  logic [15:0] seed_r;

  // Per-run counters; seq_r/ts_r/rr_r/lfsr_r hold the values for the next word.
  logic [11:0] seq_r;
  logic [15:0] ts_r;
  logic [7:0]  gap_r;
  logic [1:0]  rr_r;
  logic [15:0] lfsr_r;

  logic [7:0]  interval_eff;
  logic [15:0] seed_eff;
  logic        emit_due;
  logic        last_pkt;
  logic        can_start;
  logic        unused_wdata;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [1:0] pick_dst(input logic [1:0] mode,
                                          input logic [1:0] fixed_dst,
                                          input logic [1:0] rr,
                                          input logic [15:0] lfsr);
    case (mode)
      2'd1:    return rr;
      2'd2:    return lfsr[1:0];
      default: return fixed_dst;
    endcase
  endfunction

  function automatic logic [META_WIDTH-1:0] meta_word(input logic [1:0]  dst,
                                                      input logic [11:0] seq,
                                                      input logic [15:0] ts);
    return {dst, SRC_ID, seq, ts};
  endfunction

  assign interval_eff = (interval_r == 8'd0) ? 8'd1 : interval_r;
  assign seed_eff     = (seed_r == 16'd0) ? SEED_DFLT : seed_r;
  // gap_r counts edges since the last emission, so a word is due once it
  // reaches the effective interval.
  assign emit_due     = (gap_r >= interval_eff);
  assign last_pkt     = (sent_cnt == pkt_cnt_r - 16'd1);
  assign can_start    = start && (pkt_cnt_r != 16'd0);
  assign unused_wdata = ^cfg_wdata[31:16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      pkt_cnt_r        <= 16'd0;
      interval_r       <= 8'd1;
      mode_r           <= 2'd0;
      fixed_dst_r      <= 2'd0;
      seed_r           <= SEED_DFLT;
      seq_r            <= 12'd0;
      ts_r             <= 16'd0;
      gap_r            <= 8'd0;
      rr_r             <= 2'd0;
      lfsr_r           <= 16'd0;
      meta_if.gen_meta <= '0;
      meta_if.gen_en   <= 1'b0;
      experimenting    <= 1'b0;
      done             <= 1'b0;
      sent_cnt         <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (can_start) begin
            // Packet 0 leaves on the start edge with all run counters cleared.
            meta_if.gen_en   <= 1'b1;
            meta_if.gen_meta <= meta_word(pick_dst(mode_r, fixed_dst_r, 2'd0, seed_eff),
                                          12'd0, 16'd0);
            seq_r            <= 12'd1;
            ts_r             <= 16'd1;
            gap_r            <= 8'd1;
            rr_r             <= 2'd1;
            lfsr_r           <= lfsr_step(seed_eff);
            sent_cnt         <= 16'd1;
            experimenting    <= 1'b1;
            done             <= 1'b0;
            state            <= (pkt_cnt_r == 16'd1) ? DONE : RUN;
          end else begin
            meta_if.gen_en <= 1'b0;
            experimenting  <= 1'b0;
            if (cfg_we) begin
              case (cfg_addr)
                2'd0: pkt_cnt_r <= cfg_wdata[15:0];
                2'd1: interval_r <= cfg_wdata[7:0];
                2'd2: begin
                  mode_r      <= cfg_wdata[1:0];
                  fixed_dst_r <= cfg_wdata[3:2];
                end
                default: seed_r <= cfg_wdata[15:0];
              endcase
              done  <= 1'b0;
              state <= IDLE;
            end else if (state == DONE) begin
              // DONE is entered on the last emission edge; status follows a cycle later.
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          ts_r <= ts_r + 16'd1;
          if (stop) begin
            meta_if.gen_en <= 1'b0;
            experimenting  <= 1'b0;
            state          <= IDLE;
          end else if (emit_due) begin
            meta_if.gen_en   <= 1'b1;
            meta_if.gen_meta <= meta_word(pick_dst(mode_r, fixed_dst_r, rr_r, lfsr_r),
                                          seq_r, ts_r);
            seq_r            <= seq_r + 12'd1;
            rr_r             <= rr_r + 2'd1;
            lfsr_r           <= lfsr_step(lfsr_r);
            gap_r            <= 8'd1;
            if (sent_cnt != pkt_cnt_r) sent_cnt <= sent_cnt + 16'd1;
            if (last_pkt) state <= DONE;
          end else begin
            meta_if.gen_en <= 1'b0;
            gap_r          <= gap_r + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_gen.sv
// tb_pkt_gen: self-checking bench for pkt_gen (SRC_ID = 1).
// A run-level model predicts every output from the run parameters and the
// number of cycles since the start edge; literal checks pin the model.
module tb_pkt_gen;

  localparam int BIG = 32'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        start;
  logic        stop;
  logic        experimenting;
  logic        done;
  logic [15:0] sent_cnt;

  pkt_gen_if #(.META_WIDTH(32)) mif ();

  pkt_gen #(.SRC_ID(2'd1), .META_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .start         (start),
    .stop          (stop),
    .meta_if       (mif),
    .experimenting (experimenting),
    .done          (done),
    .sent_cnt      (sent_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Programmed registers as software sees them.
  int          m_cnt, m_iv, m_mode, m_fixed;
  logic [15:0] m_seed;
  // Snapshot of the current/last run.
  bit          active;
  int          r_cnt, r_iv, r_mode, r_fixed;
  int          c_start, stop_n, clr_n;
  logic [1:0]  dtab [0:8191];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int n_now();
    return cyc - c_start + 1;
  endfunction

  function automatic int n_last();
    return 1 + (r_cnt - 1) * r_iv;
  endfunction

  function automatic bit running(input int n);
    return active && (n < stop_n) && (n < n_last());
  endfunction

  function automatic logic [31:0] word_of(input int k);
    int d;
    if (r_mode == 1)      d = k % 4;
    else if (r_mode == 2) d = int'(dtab[k % 8192]);
    else                  d = r_fixed;
    return 32'((d << 30) | (1 << 28) | ((k % 4096) << 16) | ((k * r_iv) % 65536));
  endfunction

  task automatic model_reset();
    active = 0; m_cnt = 0; m_iv = 1; m_mode = 0; m_fixed = 0; m_seed = 16'hACE1;
    r_cnt = 1; r_iv = 1; r_mode = 0; r_fixed = 0;
    c_start = 0; stop_n = BIG; clr_n = BIG;
  endtask

  task automatic check_cycle();
    logic [31:0] e_meta;
    bit e_en, e_exp, e_done, st;
    int e_sent, n, nl, le;
    e_meta = 0; e_en = 0; e_exp = 0; e_done = 0; e_sent = 0;
    if (active) begin
      n  = n_now();
      nl = n_last();
      st = (n >= stop_n);
      le = st ? stop_n - 1 : n;
      e_sent = (le - 1) / r_iv + 1;
      if (e_sent > r_cnt) e_sent = r_cnt;
      e_en   = !st && ((n - 1) % r_iv == 0) && ((n - 1) / r_iv < r_cnt);
      e_exp  = !st && (n <= nl);
      e_done = !st && (n > nl) && (n <= clr_n);
      e_meta = word_of(e_sent - 1);
    end
    cmp("gen_en", 32'(mif.gen_en), 32'(e_en));
    cmp("gen_meta", mif.gen_meta, e_meta);
    cmp("experimenting", 32'(experimenting), 32'(e_exp));
    cmp("done", 32'(done), 32'(e_done));
    cmp("sent_cnt", 32'(sent_cnt), 32'(e_sent));
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_en && reset) check_cycle();
  end

  task automatic cfg(input int addr, input int val);
    int n;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(addr); cfg_wdata = 32'(val);
    n = n_now();
    if (!running(n)) begin
      case (addr)
        0: m_cnt = val & 32'hFFFF;
        1: m_iv = val & 32'hFF;
        2: begin m_mode = val & 3; m_fixed = (val >> 2) & 3; end
        default: m_seed = 16'(val);
      endcase
      if (active && n < stop_n && n >= n_last() && n < clr_n) clr_n = n;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    logic [15:0] s;
    @(negedge clk);
    start = 1'b1;
    if (!running(n_now()) && m_cnt != 0) begin
      r_cnt = m_cnt; r_iv = (m_iv == 0) ? 1 : m_iv; r_mode = m_mode; r_fixed = m_fixed;
      s = (m_seed == 16'd0) ? 16'hACE1 : m_seed;
      for (int k = 0; k < r_cnt && k < 8192; k++) begin
        dtab[k] = s[1:0];
        s = {s[14:0], ^(s & 16'hB400)};
      end
      c_start = cyc + 1; stop_n = BIG; clr_n = BIG; active = 1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    if (running(n_now())) stop_n = n_now() + 1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, "_gen_en"}, 32'(mif.gen_en), 32'd0);
    cmp({nm, "_gen_meta"}, mif.gen_meta, 32'd0);
    cmp({nm, "_exp"}, 32'(experimenting), 32'd0);
    cmp({nm, "_done"}, 32'(done), 32'd0);
    cmp({nm, "_sent"}, 32'(sent_cnt), 32'd0);
  endtask

  logic [31:0] basic_w [4];
  logic [1:0]  rr_lit [6];
  logic [1:0]  lf_lit [3];

  initial begin
    int cnt, iv, md, fx, sd, ive;
    basic_w = '{32'h9000_0000, 32'h9001_0003, 32'h9002_0006, 32'h9003_0009};
    rr_lit  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    lf_lit  = '{2'd1, 2'd3, 2'd3};
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    chk_en = 1;

    // Basic fixed-destination run.
    cfg(0, 4); cfg(1, 3); cfg(2, 32'h8);
    do_start();
    for (int j = 1; j <= 11; j++) begin
      if ((j - 1) % 3 == 0 && j <= 10) begin
        cmp("basic_en", 32'(mif.gen_en), 32'd1);
        cmp("basic_word", mif.gen_meta, basic_w[(j - 1) / 3]);
      end else begin
        cmp("basic_gap", 32'(mif.gen_en), 32'd0);
      end
      if (j == 11) begin
        cmp("basic_done", 32'(done), 32'd1);
        cmp("basic_sent", 32'(sent_cnt), 32'd4);
        cmp("basic_exp", 32'(experimenting), 32'd0);
      end else begin
        @(negedge clk);
      end
    end

    // Back-to-back round-robin.
    cfg(1, 0); cfg(2, 1); cfg(0, 6);
    do_start();
    for (int j = 1; j <= 7; j++) begin
      if (j <= 6) begin
        cmp("rr_en", 32'(mif.gen_en), 32'd1);
        cmp("rr_dst", 32'(mif.gen_meta[31:30]), 32'(rr_lit[j - 1]));
        @(negedge clk);
      end else begin
        cmp("rr_exp_fall", 32'(experimenting), 32'd0);
      end
    end

    // LFSR mode with SEED=0, run twice.
    cfg(3, 0); cfg(2, 2); cfg(1, 2); cfg(0, 3);
    for (int r = 0; r < 2; r++) begin
      do_start();
      for (int j = 1; j <= 5; j++) begin
        if (j % 2 == 1) cmp("lfsr_dst", 32'(mif.gen_meta[31:30]), 32'(lf_lit[(j - 1) / 2]));
        @(negedge clk);
      end
      repeat (3) @(negedge clk);
    end

    // Abort after two packets.
    cfg(2, 0); cfg(1, 2); cfg(0, 10);
    do_start();
    @(negedge clk);
    do_stop();
    cmp("abort_exp", 32'(experimenting), 32'd0);
    cmp("abort_done", 32'(done), 32'd0);
    cmp("abort_sent", 32'(sent_cnt), 32'd2);
    for (int j = 0; j < 4; j++) begin
      cmp("abort_no_en", 32'(mif.gen_en), 32'd0);
      @(negedge clk);
    end

    // Configuration write during RUN is ignored; write in DONE clears done.
    cfg(0, 5); cfg(1, 4);
    do_start();
    cfg(0, 2);
    repeat (20) @(negedge clk);
    cmp("cfgrun_sent", 32'(sent_cnt), 32'd5);
    cmp("cfgrun_done", 32'(done), 32'd1);
    cfg(1, 1);
    cmp("cfgdone_clear", 32'(done), 32'd0);

    // Start with PKT_CNT=0 has no effect.
    cfg(0, 0);
    do_start();
    for (int j = 0; j < 3; j++) begin
      cmp("cnt0_exp", 32'(experimenting), 32'd0);
      cmp("cnt0_sent", 32'(sent_cnt), 32'd5);
      @(negedge clk);
    end

    // Reset mid-run, then defaults after release.
    cfg(0, 8); cfg(1, 2);
    do_start();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    do_start();
    cmp("dflt_cnt0_exp", 32'(experimenting), 32'd0);
    cfg(0, 3);
    do_start();
    for (int j = 1; j <= 3; j++) begin
      cmp("dflt_en", 32'(mif.gen_en), 32'd1);
      cmp("dflt_word", mif.gen_meta, 32'h1000_0000 | 32'((j - 1) << 16) | 32'(j - 1));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // Randomized runs, unused upper write bits randomized too.
    for (int r = 0; r < 14; r++) begin
      cnt = $urandom_range(1, 24);
      iv  = $urandom_range(0, 5);
      md  = $urandom_range(0, 3);
      fx  = $urandom_range(0, 3);
      sd  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 65535);
      ive = (iv == 0) ? 1 : iv;
      cfg(0, int'(32'(cnt) | ($urandom() & 32'hFFFF_0000)));
      cfg(1, int'(32'(iv) | ($urandom() & 32'hFFFF_FF00)));
      cfg(2, int'(32'(md | (fx << 2)) | ($urandom() & 32'hFFFF_FFF0)));
      cfg(3, int'(32'(sd) | ($urandom() & 32'hFFFF_0000)));
      do_start();
      if ($urandom_range(0, 3) == 0) cfg(0, $urandom_range(1, 30));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, cnt * ive)) @(negedge clk);
        do_stop();
      end
      repeat (cnt * ive + 4) @(negedge clk);
    end

    // Sequence wrap and long run.
    cfg(2, 1); cfg(1, 1); cfg(0, 4100);
    do_start();
    repeat (4096) @(negedge clk);
    cmp("wrap_en", 32'(mif.gen_en), 32'd1);
    cmp("wrap_seq", 32'(mif.gen_meta[27:16]), 32'd0);
    cmp("wrap_ts", 32'(mif.gen_meta[15:0]), 32'd4096);
    repeat (6) @(negedge clk);
    cmp("wrap_sent", 32'(sent_cnt), 32'd4100);
    cmp("wrap_done", 32'(done), 32'd1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
